// File: rtl/fsm_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// fsm_dispatch_pkg
// Shared definitions for the multicycle RV64 instruction sequencer:
//   - sequencer state encoding
//   - RV64 major opcodes used for classification
//   - one-hot start constants driven to fsm_combined
//   - classifier result struct
// ---------------------------------------------------------------------------
package fsm_dispatch_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH_REQ  = 3'd1,
      S_FETCH_WAIT = 3'd2,
      S_DECODE     = 3'd3,
      S_EXEC       = 3'd4,
      S_RETIRE     = 3'd5,
      S_HALT       = 3'd6,
      S_TRAP       = 3'd7
   } state_t;

   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_OP32     = 7'b0111011;
   localparam logic [6:0] OP_IMM32    = 7'b0011011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OP_STORE_FP = 7'b0100111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   localparam logic [2:0] START_NONE = 3'b000;
   localparam logic [2:0] START_ALU  = 3'b001;
   localparam logic [2:0] START_BRJ  = 3'b010;
   localparam logic [2:0] START_LDST = 3'b100;

   typedef struct packed {
      logic [2:0] start;
      logic       is_system;
      logic       is_illegal;
   } opclass_t;

endpackage

// File: rtl/fsm_dispatch_opcode_classifier.sv
// ---------------------------------------------------------------------------
// opcode_classifier
// Combinational decode of an RV64 major opcode into the sub-FSM that must
// execute it.
//   i_opcode  in  7   insn[6:0]
//   o_class   out     {start one-hot, is_system, is_illegal}
// Exactly one of: start non-zero, is_system, is_illegal.
// ---------------------------------------------------------------------------
module opcode_classifier
   import fsm_dispatch_pkg::*;
(
   input  logic [6:0] i_opcode,
   output opclass_t   o_class
);

   always_comb begin
      o_class.start      = START_NONE;
      o_class.is_system  = 1'b0;
      o_class.is_illegal = 1'b0;
      case (i_opcode)
         OP_OP, OP_IMM, OP_OP32, OP_IMM32, OP_LUI, OP_AUIPC:
            o_class.start = START_ALU;
         OP_BRANCH, OP_JAL, OP_JALR:
            o_class.start = START_BRJ;
         OP_LOAD, OP_STORE, OP_LOAD_FP, OP_STORE_FP:
            o_class.start = START_LDST;
         OP_SYSTEM:
            o_class.is_system = 1'b1;
         default:
            o_class.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/fsm_dispatch.sv
// ---------------------------------------------------------------------------
// fsm_dispatch
// Top-level instruction sequencer of the multicycle RV64 core. Fetches an
// instruction over the shared memory port, classifies it, hands it to one
// execution FSM through a held one-hot start, retires it, and loops. Traps on
// illegal opcodes and on an execution FSM that never reports done.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst_n          in   1      async reset, active low
//   run            in   1      1 = keep executing, 0 = stop at next boundary
//   mem_rdata      in   32     instruction word, valid with memory_done
//   memory_done    in   1      memory handshake complete
//   done           in   1      done from fsm_combined
//   fetch_start    out  1      1-cycle fetch request
//   sel_mem_fetch  out  1      memory port owned by fetch
//   insn           out  32     current instruction
//   start          out  3      one-hot: 001 ALU, 010 BR/J, 100 LD/ST
//   retire         out  1      1-cycle pulse per retired instruction
//   insn_count     out  CNT_W  retired-instruction count (wraps)
//   halted         out  1      sticky: SYSTEM opcode reached
//   illegal        out  1      sticky: unknown opcode
//   timeout        out  1      sticky: watchdog expired
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | stopped, waiting for run
// S_FETCH_REQ  | fetch_start pulse, memory port owned by fetch
// S_FETCH_WAIT | waiting for memory_done, latch instruction word
// S_DECODE     | classify opcode, pick sub-FSM / halt / trap
// S_EXEC       | start held, waiting for done, watchdog running
// S_RETIRE     | retire pulse, count++, continue or stop
// S_HALT       | SYSTEM reached, terminal until reset
// S_TRAP       | illegal opcode or watchdog, terminal until reset
// ---------------------------------------------------------------------------
module fsm_dispatch
   import fsm_dispatch_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 1024
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [31:0]      mem_rdata,
   input  logic             memory_done,
   input  logic             done,
   output logic             fetch_start,
   output logic             sel_mem_fetch,
   output logic [31:0]      insn,
   output logic [2:0]       start,
   output logic             retire,
   output logic [CNT_W-1:0] insn_count,
   output logic             halted,
   output logic             illegal,
   output logic             timeout
);

   // Down-counter: loaded with TIMEOUT-1 on entry to EXEC, so it reads zero
   // on the TIMEOUT-th EXEC cycle.
   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic            WD_EN   = (TIMEOUT > 0);

   state_t           r_state;
   logic [31:0]      r_insn;
   logic [2:0]       r_start;
   logic [WD_W-1:0]  r_wdog;
   logic [CNT_W-1:0] r_insn_count;
   logic             r_fetch_start;
   logic             r_sel_mem_fetch;
   logic             r_retire;
   logic             r_halted;
   logic             r_illegal;
   logic             r_timeout;
   opclass_t         w_class;

   opcode_classifier u_classifier (
      .i_opcode (r_insn[6:0]),
      .o_class  (w_class)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_insn          <= '0;
         r_start         <= START_NONE;
         r_wdog          <= '0;
         r_insn_count    <= '0;
         r_fetch_start   <= 1'b0;
         r_sel_mem_fetch <= 1'b0;
         r_retire        <= 1'b0;
         r_halted        <= 1'b0;
         r_illegal       <= 1'b0;
         r_timeout       <= 1'b0;
      end else begin
         r_fetch_start <= 1'b0;
         r_retire      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state         <= S_FETCH_REQ;
                  r_fetch_start   <= 1'b1;
                  r_sel_mem_fetch <= 1'b1;
               end
            end
            S_FETCH_REQ: begin
               r_state <= S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
               if (memory_done) begin
                  r_insn          <= mem_rdata;
                  r_sel_mem_fetch <= 1'b0;
                  r_state         <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (w_class.is_system) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (w_class.is_illegal) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_TRAP;
               end else begin
                  r_start <= w_class.start;
                  r_wdog  <= WD_LOAD;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // done takes priority over a watchdog expiring in the same cycle
               if (done) begin
                  r_start      <= START_NONE;
                  r_retire     <= 1'b1;
                  r_insn_count <= r_insn_count + CNT_W'(1);
                  r_state      <= S_RETIRE;
               end else if (WD_EN && (r_wdog == '0)) begin
                  r_start   <= START_NONE;
                  r_timeout <= 1'b1;
                  r_state   <= S_TRAP;
               end else begin
                  r_wdog <= r_wdog - WD_W'(1);
               end
            end
            S_RETIRE: begin
               if (run) begin
                  r_state         <= S_FETCH_REQ;
                  r_fetch_start   <= 1'b1;
                  r_sel_mem_fetch <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_HALT, S_TRAP: begin
               r_state <= r_state;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign fetch_start   = r_fetch_start;
   assign sel_mem_fetch = r_sel_mem_fetch;
   assign insn          = r_insn;
   assign start         = r_start;
   assign retire        = r_retire;
   assign insn_count    = r_insn_count;
   assign halted        = r_halted;
   assign illegal       = r_illegal;
   assign timeout       = r_timeout;

endmodule

// File: tb/tb_fsm_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fsm_dispatch
// Self-checking bench for fsm_dispatch. Inputs change and outputs are sampled
// on the falling clock edge. Expected start/flags come from an opcode-set
// model; expected count from a running total.
// ---------------------------------------------------------------------------
module tb_fsm_dispatch;

   localparam int CNT_W = 64;
   localparam int TMO   = 8;

   logic             clk;
   logic             rst_n;
   logic             run;
   logic [31:0]      mem_rdata;
   logic             memory_done;
   logic             done;
   logic             fetch_start;
   logic             sel_mem_fetch;
   logic [31:0]      insn;
   logic [2:0]       start;
   logic             retire;
   logic [CNT_W-1:0] insn_count;
   logic             halted;
   logic             illegal;
   logic             timeout;

   int               n_cmp;
   int               n_bad;
   logic [CNT_W-1:0] exp_count;

   fsm_dispatch #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .mem_rdata     (mem_rdata),
      .memory_done   (memory_done),
      .done          (done),
      .fetch_start   (fetch_start),
      .sel_mem_fetch (sel_mem_fetch),
      .insn          (insn),
      .start         (start),
      .retire        (retire),
      .insn_count    (insn_count),
      .halted        (halted),
      .illegal       (illegal),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation still running at %0t, required finish", $time);
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   function automatic logic [2:0] model_start(input logic [31:0] w);
      logic [6:0] op;
      op = w[6:0];
      if (op inside {7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17}) return 3'b001;
      if (op inside {7'h63, 7'h6F, 7'h67})                      return 3'b010;
      if (op inside {7'h03, 7'h23, 7'h07, 7'h27})               return 3'b100;
      return 3'b000;
   endfunction

   function automatic bit model_system(input logic [31:0] w);
      return w[6:0] == 7'h73;
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [6:0]  ops [13];
      logic [31:0] r;
      ops = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h63,
              7'h6F, 7'h67, 7'h03, 7'h23, 7'h07, 7'h27};
      r = $urandom;
      return {r[31:7], ops[$urandom_range(0, 12)]};
   endfunction

   function automatic logic [31:0] rand_illegal();
      logic [31:0] r;
      r = $urandom;
      while (model_start(r) != 3'b000 || model_system(r)) r = $urandom;
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst_n       = 1'b0;
      run         = 1'b0;
      done        = 1'b0;
      memory_done = 1'b0;
      mem_rdata   = '0;
      exp_count   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Drives one complete instruction. exec_lat = EXEC cycles before done;
   // exec_lat = 0 means done is never given (watchdog expected).
   task automatic run_insn(input logic [31:0] w, input int mem_lat,
                           input int exec_lat, input bit drop_run);
      logic [2:0] es;
      int         k;
      int         limit;
      es = model_start(w);
      k  = 0;
      while (fetch_start !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (fetch_start !== 1'b1) begin
         n_bad++;
         $display("FAIL fetch_start_wait: fetch_start=%b required 1 within 20 cycles", fetch_start);
         return;
      end
      n_cmp++;
      if (sel_mem_fetch !== 1'b1 || start !== 3'b000) begin
         n_bad++;
         $display("FAIL fetch_req_outputs: sel=%b start=%b required sel=1 start=000", sel_mem_fetch, start);
      end
      if (drop_run) run = 1'b0;
      done = 1'($urandom_range(0, 1));
      repeat (mem_lat) @(negedge clk);
      n_cmp++;
      if (fetch_start !== 1'b0 || sel_mem_fetch !== 1'b1) begin
         n_bad++;
         $display("FAIL fetch_wait_outputs: fetch_start=%b sel=%b required 0 1", fetch_start, sel_mem_fetch);
      end
      mem_rdata   = w;
      memory_done = 1'b1;
      @(negedge clk);
      memory_done = 1'b0;
      done        = 1'b0;
      mem_rdata   = $urandom;
      n_cmp++;
      if (insn !== w || start !== 3'b000 || sel_mem_fetch !== 1'b0) begin
         n_bad++;
         $display("FAIL decode_insn: insn=%h start=%b sel=%b required insn=%h start=000 sel=0",
                  insn, start, sel_mem_fetch, w);
      end
      @(negedge clk);
      if (model_system(w) || es == 3'b000) begin
         n_cmp++;
         if (halted !== model_system(w) || illegal !== !model_system(w) ||
             start !== 3'b000 || retire !== 1'b0 || insn_count !== exp_count) begin
            n_bad++;
            $display("FAIL terminal_entry: halted=%b illegal=%b start=%b retire=%b count=%0d required %b %b 000 0 %0d",
                     halted, illegal, start, retire, insn_count,
                     model_system(w), !model_system(w), exp_count);
         end
         return;
      end
      limit = (exec_lat == 0) ? TMO : exec_lat;
      for (int i = 1; i <= limit; i++) begin
         n_cmp++;
         if (start !== es) begin
            n_bad++;
            $display("FAIL exec_start_hold: cycle %0d start=%b required %b", i, start, es);
         end
         memory_done = 1'($urandom_range(0, 1));
         if (i == exec_lat) done = 1'b1;
         @(negedge clk);
         done        = 1'b0;
         memory_done = 1'b0;
      end
      if (exec_lat != 0) begin
         exp_count = exp_count + 1'b1;
         n_cmp++;
         if (retire !== 1'b1 || start !== 3'b000 || insn_count !== exp_count || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL retire_pulse: retire=%b start=%b count=%h timeout=%b required 1 000 %h 0",
                     retire, start, insn_count, timeout, exp_count);
         end
         if (drop_run) begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               n_cmp++;
               if (fetch_start !== 1'b0 || retire !== 1'b0 || sel_mem_fetch !== 1'b0) begin
                  n_bad++;
                  $display("FAIL stop_after_retire: fetch_start=%b retire=%b sel=%b required 0 0 0",
                           fetch_start, retire, sel_mem_fetch);
               end
            end
         end
      end else begin
         n_cmp++;
         if (timeout !== 1'b1 || start !== 3'b000 || retire !== 1'b0 || insn_count !== exp_count) begin
            n_bad++;
            $display("FAIL watchdog_trap: timeout=%b start=%b retire=%b count=%0d required 1 000 0 %0d",
                     timeout, start, retire, insn_count, exp_count);
         end
      end
   endtask

   // Terminal states must ignore run, done and memory_done.
   task automatic check_terminal(input logic [31:0] w);
      logic hz;
      logic il;
      logic to;
      hz = halted;
      il = illegal;
      to = timeout;
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         done        = 1'($urandom_range(0, 1));
         memory_done = 1'($urandom_range(0, 1));
         mem_rdata   = $urandom;
         @(negedge clk);
         n_cmp++;
         if (fetch_start !== 1'b0 || start !== 3'b000 || retire !== 1'b0 || insn !== w ||
             insn_count !== exp_count || {halted, illegal, timeout} !== {hz, il, to} ||
             {hz, il, to} == 3'b000) begin
            n_bad++;
            $display("FAIL terminal_hold: fs=%b start=%b retire=%b insn=%h flags=%b required 0 000 0 %h sticky nonzero",
                     fetch_start, start, retire, insn, {halted, illegal, timeout}, w);
         end
      end
      done        = 1'b0;
      memory_done = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      run   = 1'b1;
      done  = 1'b1;
      memory_done = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({fetch_start, sel_mem_fetch, insn, start, retire, insn_count, halted, illegal, timeout} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: fs=%b sel=%b insn=%h start=%b retire=%b count=%0d flags=%b required all 0",
                  fetch_start, sel_mem_fetch, insn, start, retire, insn_count, {halted, illegal, timeout});
      end
      do_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (fetch_start !== 1'b0 || sel_mem_fetch !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_no_run: fetch_start=%b sel=%b required 0 0", fetch_start, sel_mem_fetch);
      end
   endtask

   task automatic test_add();
      do_reset();
      run = 1'b1;
      run_insn(32'h003100B3, 2, 3, 1'b0);
   endtask

   task automatic test_sequence();
      do_reset();
      run = 1'b1;
      run_insn(32'h00208063, 1, 2, 1'b0);
      run_insn(32'h00012083, 3, 1, 1'b0);
      run_insn(32'h00112023, 2, 4, 1'b0);
      n_cmp++;
      if (insn_count !== 64'd3) begin
         n_bad++;
         $display("FAIL sequence_count: count=%0d required 3", insn_count);
      end
   endtask

   task automatic test_random();
      do_reset();
      run = 1'b1;
      for (int n = 0; n < 30; n++)
         run_insn(rand_legal(), $urandom_range(1, 4), $urandom_range(1, TMO - 1), 1'b0);
      // done on the very cycle the watchdog would expire: done wins
      run_insn(rand_legal(), 1, TMO, 1'b0);
   endtask

   task automatic test_illegal();
      do_reset();
      run = 1'b1;
      run_insn(32'h0000007F, 1, 1, 1'b0);
      check_terminal(32'h0000007F);
      do_reset();
      run = 1'b1;
      run_insn(32'h00000033, 1, 2, 1'b0);
      begin
         logic [31:0] w;
         w = rand_illegal();
         run_insn(w, 2, 1, 1'b0);
         check_terminal(w);
      end
   endtask

   task automatic test_ecall();
      do_reset();
      run = 1'b1;
      run_insn(32'h00000013, 1, 1, 1'b0);
      run_insn(32'h00000073, 2, 1, 1'b0);
      check_terminal(32'h00000073);
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      do_reset();
      run = 1'b1;
      w = rand_legal();
      run_insn(w, 1, 0, 1'b0);
      check_terminal(w);
   endtask

   task automatic test_run_drop();
      do_reset();
      run = 1'b1;
      run_insn(32'h00A00093, 3, 2, 1'b1);
      run = 1'b1;
      run_insn(32'h0000006F, 1, 1, 1'b0);
   endtask

   task automatic test_reset_mid_exec();
      int k;
      do_reset();
      run = 1'b1;
      run_insn(32'h00000013, 1, 1, 1'b0);
      k = 0;
      while (fetch_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      mem_rdata   = 32'h00012083;
      memory_done = 1'b1;
      @(negedge clk);
      memory_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (start !== 3'b100) begin
         n_bad++;
         $display("FAIL mid_exec_setup: start=%b required 100", start);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({fetch_start, sel_mem_fetch, insn, start, retire, insn_count, halted, illegal, timeout} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: start=%b insn=%h count=%0d flags=%b required all 0",
                  start, insn, insn_count, {halted, illegal, timeout});
      end
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b0;
      exp_count = '0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      do_reset();
      force dut.r_insn_count = {CNT_W{1'b1}};
      #1;
      release dut.r_insn_count;
      exp_count = {CNT_W{1'b1}};
      run = 1'b1;
      run_insn(32'h00000013, 1, 2, 1'b0);
      n_cmp++;
      if (insn_count !== '0) begin
         n_bad++;
         $display("FAIL count_wrap: count=%h required 0", insn_count);
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      exp_count   = '0;
      rst_n       = 1'b0;
      run         = 1'b0;
      done        = 1'b0;
      memory_done = 1'b0;
      mem_rdata   = '0;
      test_reset();
      test_add();
      test_sequence();
      test_random();
      test_illegal();
      test_ecall();
      test_timeout();
      test_run_drop();
      test_reset_mid_exec();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
